// File: rtl/beta_irq_ctrl_if.sv
// Interrupt-controller bus: source levels, masks and ack in; request, id, pending and core reset out.
interface beta_irq_ctrl_if #(
   parameter int unsigned NCH = 4
);
   localparam int unsigned VEC_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]   irq_src;
   logic [NCH-1:0]   irq_mask;
   logic             irq_ack;
   logic             IRQ;
   logic [VEC_W-1:0] irq_id;
   logic [NCH-1:0]   pending;
   logic             cpu_rst;

   // Side that drives sources and acknowledges (platform / processor)
   modport master (
      output irq_src, irq_mask, irq_ack,
      input  IRQ, irq_id, pending, cpu_rst
   );

   // Side implemented by the controller
   modport slave (
      input  irq_src, irq_mask, irq_ack,
      output IRQ, irq_id, pending, cpu_rst
   );
endinterface

// File: rtl/beta_irq_ctrl.sv
// Beta interrupt controller: synchronised edge capture, fixed lowest-index priority,
// single outstanding request with ack, and a stretched reset for the core.
module beta_irq_ctrl #(
   parameter int unsigned NCH      = 4,
   parameter int unsigned RST_HOLD = 2
) (
   input  logic           clk,
   input  logic           RESET,
   beta_irq_ctrl_if.slave bus
);
   localparam int unsigned VEC_W = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_IDLE = 2'd1,
      S_REQ  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [NCH-1:0]   r_s1;
   logic [NCH-1:0]   r_s2;
   logic [NCH-1:0]   r_prev;
   logic [NCH-1:0]   r_pending;
   logic [7:0]       r_cnt;
   logic             r_irq;
   logic [VEC_W-1:0] r_irq_id;
   logic             r_cpu_rst;

   logic [NCH-1:0]   w_rise;
   logic [NCH-1:0]   w_avail;
   logic [VEC_W-1:0] w_low_id;
   logic [NCH-1:0]   w_set;
   logic [NCH-1:0]   w_clr;
   logic [NCH-1:0]   w_pending_nx;
   logic [7:0]       w_cnt_inc;
   logic [7:0]       w_cnt_nx;
   logic             w_irq_nx;
   logic [VEC_W-1:0] w_irq_id_nx;
   logic             w_cpu_rst_nx;

   assign w_rise    = r_s2 & ~r_prev;
   assign w_avail   = r_pending & bus.irq_mask;
   assign w_cnt_inc = r_cnt + 8'd1;

   // Lowest enabled pending channel wins
   always_comb begin
      w_low_id = '0;
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
         if (w_avail[i]) w_low_id = VEC_W'(i);
      end
   end

   // Next state, next outputs and pending update
   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_irq_nx     = r_irq;
      w_irq_id_nx  = r_irq_id;
      w_cpu_rst_nx = r_cpu_rst;
      w_set        = w_rise;
      w_clr        = '0;
      case (r_state)
         S_HOLD: begin
            // Edges seen while the core is held in reset are dropped
            w_set        = '0;
            w_irq_nx     = 1'b0;
            w_cpu_rst_nx = 1'b1;
            w_cnt_nx     = w_cnt_inc;
            if (w_cnt_inc == 8'(RST_HOLD)) begin
               w_state_nx   = S_IDLE;
               w_cpu_rst_nx = 1'b0;
            end
         end
         S_IDLE: begin
            if (|w_avail) begin
               w_state_nx  = S_REQ;
               w_irq_nx    = 1'b1;
               w_irq_id_nx = w_low_id;
            end
         end
         S_REQ: begin
            if (bus.irq_ack) begin
               w_state_nx = S_IDLE;
               w_irq_nx   = 1'b0;
               w_clr      = NCH'(1) << r_irq_id;
            end
         end
         default: begin
            w_state_nx   = S_HOLD;
            w_irq_nx     = 1'b0;
            w_cpu_rst_nx = 1'b1;
         end
      endcase
      // A fresh edge on the acknowledged channel overrides its clear
      w_pending_nx = (r_pending & ~w_clr) | w_set;
   end

   // State, synchroniser and registered outputs
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_state   <= S_HOLD;
         r_s1      <= '0;
         r_s2      <= '0;
         r_prev    <= '0;
         r_pending <= '0;
         r_cnt     <= '0;
         r_irq     <= 1'b0;
         r_irq_id  <= '0;
         r_cpu_rst <= 1'b1;
      end else begin
         r_state   <= w_state_nx;
         r_s1      <= bus.irq_src;
         r_s2      <= r_s1;
         r_prev    <= r_s2;
         r_pending <= w_pending_nx;
         r_cnt     <= w_cnt_nx;
         r_irq     <= w_irq_nx;
         r_irq_id  <= w_irq_id_nx;
         r_cpu_rst <= w_cpu_rst_nx;
      end
   end

   assign bus.IRQ     = r_irq;
   assign bus.irq_id  = r_irq_id;
   assign bus.pending = r_pending;
   assign bus.cpu_rst = r_cpu_rst;
endmodule

// File: tb/tb_beta_irq_ctrl.sv
// Self-checking bench for beta_irq_ctrl: directed scenarios then randomized traffic,
// every cycle compared against a behavioural model of the controller.
module tb_beta_irq_ctrl;
   localparam int NCH      = 4;
   localparam int RST_HOLD = 2;

   logic clk;
   logic RESET;
   int   n_vec;
   int   n_err;

   beta_irq_ctrl_if #(.NCH(NCH)) bus ();

   beta_irq_ctrl #(.NCH(NCH), .RST_HOLD(RST_HOLD)) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: source samples of the last three edges, request flag, presented id, pending set
   logic [NCH-1:0] m_s1, m_s2, m_s3;
   logic [NCH-1:0] m_pend;
   int             m_edges;
   bit             m_req;
   int             m_id;

   function automatic int lowest(input logic [NCH-1:0] v);
      int idx;
      idx = 0;
      while (!v[idx]) idx++;
      return idx;
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_s3 = '0;
      m_pend = '0; m_edges = 0; m_req = 0; m_id = 0;
   endtask

   task automatic model_edge();
      logic [NCH-1:0] rise, clr, avail;
      bit hold_pre;
      hold_pre = (m_edges < RST_HOLD);
      rise  = m_s2 & ~m_s3;
      clr   = '0;
      avail = m_pend & bus.irq_mask;
      if (!hold_pre) begin
         if (m_req) begin
            if (bus.irq_ack) begin
               m_req = 0;
               clr[m_id] = 1'b1;
            end
         end else if (avail != '0) begin
            m_req = 1;
            m_id  = lowest(avail);
         end
      end
      m_pend = (m_pend & ~clr) | (hold_pre ? '0 : rise);
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = bus.irq_src;
      if (m_edges < 1000) m_edges++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("irq",     32'(bus.IRQ),     32'(m_req));
      chk("irq_id",  32'(bus.irq_id),  32'(m_id));
      chk("pending", 32'(bus.pending), 32'(m_pend));
      chk("cpu_rst", 32'(bus.cpu_rst), 32'(m_edges < RST_HOLD));
   endtask

   // One clock edge: update the model with the inputs sampled there, then compare
   task automatic step();
      @(posedge clk);
      if (RESET) model_reset();
      else model_edge();
      #1;
      check_model();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      RESET = 1'b1;
      bus.irq_src  = '0;
      bus.irq_mask = '0;
      bus.irq_ack  = 1'b0;
      model_reset();

      // Reset state and core-reset stretch
      #3;
      check_model();
      chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      steps(2);
      RESET = 1'b0;
      step();
      chk("hold_edge1_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      step();
      chk("hold_edge2_cpu_rst", 32'(bus.cpu_rst), 32'd0);
      chk("hold_pending", 32'(bus.pending), 32'd0);
      steps(2);

      // Single channel
      bus.irq_mask = 4'b1111;
      bus.irq_src  = 4'b0100;
      steps(3);
      chk("single_pend", 32'(bus.pending), 32'h4);
      chk("single_irq_early", 32'(bus.IRQ), 32'd0);
      step();
      chk("single_irq", 32'(bus.IRQ), 32'd1);
      chk("single_id", 32'(bus.irq_id), 32'd2);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0;
      chk("single_ack_irq", 32'(bus.IRQ), 32'd0);
      chk("single_ack_pend", 32'(bus.pending), 32'd0);
      bus.irq_src = '0;
      steps(3);

      // Priority between two simultaneous edges
      bus.irq_src = 4'b1010;
      steps(4);
      chk("prio_id_first", 32'(bus.irq_id), 32'd1);
      step();
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0;
      chk("prio_gap_irq", 32'(bus.IRQ), 32'd0);
      chk("prio_gap_pend", 32'(bus.pending), 32'h8);
      step();
      chk("prio_irq_second", 32'(bus.IRQ), 32'd1);
      chk("prio_id_second", 32'(bus.irq_id), 32'd3);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0;
      bus.irq_src = '0;
      steps(3);

      // Masked channel latches but is not presented until enabled
      bus.irq_mask = 4'b1110;
      bus.irq_src  = 4'b0001;
      steps(5);
      chk("mask_pend", 32'(bus.pending), 32'h1);
      chk("mask_irq", 32'(bus.IRQ), 32'd0);
      bus.irq_mask = 4'b1111;
      step();
      chk("unmask_irq", 32'(bus.IRQ), 32'd1);
      chk("unmask_id", 32'(bus.irq_id), 32'd0);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0;
      bus.irq_src = '0;
      steps(3);

      // New edge on the presented channel in its ack cycle
      bus.irq_src = 4'b0100;
      steps(4);
      chk("coll_irq", 32'(bus.IRQ), 32'd1);
      bus.irq_src = '0;
      steps(2);
      bus.irq_src = 4'b0100;
      steps(2);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0;
      chk("coll_ack_irq", 32'(bus.IRQ), 32'd0);
      chk("coll_pend_kept", 32'(bus.pending), 32'h4);
      step();
      chk("coll_reirq", 32'(bus.IRQ), 32'd1);
      chk("coll_reid", 32'(bus.irq_id), 32'd2);
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0;
      bus.irq_src = '0;
      steps(3);

      // Asynchronous reset in the middle of a request
      bus.irq_src = 4'b1000;
      steps(4);
      chk("midrst_pre_id", 32'(bus.irq_id), 32'd3);
      #2;
      RESET = 1'b1;
      model_reset();
      #1;
      check_model();
      chk("midrst_irq", 32'(bus.IRQ), 32'd0);
      chk("midrst_pend", 32'(bus.pending), 32'd0);
      chk("midrst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      step();
      RESET = 1'b0;
      step();
      chk("midrst_hold1", 32'(bus.cpu_rst), 32'd1);
      step();
      chk("midrst_hold2", 32'(bus.cpu_rst), 32'd0);
      step();
      chk("midrst_src_high_pend", 32'(bus.pending), 32'h8);
      step();
      bus.irq_ack = 1'b1;
      step();
      bus.irq_ack = 1'b0;
      bus.irq_src = '0;
      steps(3);

      // Randomized traffic with occasional asynchronous resets
      for (int c = 0; c < 600; c++) begin
         bus.irq_src = bus.irq_src ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
         if ($urandom_range(0, 7) == 0) bus.irq_mask = 4'($urandom);
         bus.irq_ack = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 149) == 0) begin
            #2;
            RESET = 1'b1;
            model_reset();
            #1;
            check_model();
            step();
            RESET = 1'b0;
         end else begin
            step();
         end
      end
      bus.irq_ack = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
